// File: rtl/exec_pkg.sv
// ---------------------------------------------------------------------------
// exec_pkg
// Shared definitions for the instruction executor: opcode encodings,
// instruction field positions, FSM state type and small decode helpers.
// ---------------------------------------------------------------------------
package exec_pkg;

    localparam int INSTR_W = 32;

    // Opcode encodings (instruction bits [31:29])
    localparam logic [2:0] OP_NOP    = 3'b000;
    localparam logic [2:0] OP_RSVD   = 3'b001;
    localparam logic [2:0] OP_ADD    = 3'b010;
    localparam logic [2:0] OP_SUB    = 3'b011;
    localparam logic [2:0] OP_SHIFTL = 3'b100;
    localparam logic [2:0] OP_SHIFTR = 3'b101;
    localparam logic [2:0] OP_ADDI   = 3'b110;
    localparam logic [2:0] OP_SUBI   = 3'b111;

    // Field positions (LSB of each field; register fields are index-width wide)
    localparam int OP_LSB  = 29;
    localparam int OP_W    = 3;
    localparam int RS_LSB  = 24;
    localparam int RT_LSB  = 19;
    localparam int RD_LSB  = 14;
    localparam int IMM_LSB = 0;
    localparam int SHAMT_W = 5;

    typedef enum logic [2:0] {
        IDLE,
        DECODE,
        EXECUTE,
        WRITEBACK,
        HALT
    } state_t;

    // ADD..SUBI produce a register result; NOP and reserved do not.
    function automatic logic op_writes_reg(input logic [OP_W-1:0] op);
        return op >= OP_ADD;
    endfunction

    // ADDI/SUBI take an immediate and write rt.
    function automatic logic op_is_itype(input logic [OP_W-1:0] op);
        return op[2:1] == 2'b11;
    endfunction

endpackage

// File: rtl/exec_regfile.sv
// ---------------------------------------------------------------------------
// exec_regfile
// REG_COUNT x DATA_W register file, r0 hardwired to zero.
// Ports:
//   clk, reset              clock, asynchronous active-low reset
//   we, waddr, wdata        synchronous write port (writes to r0 dropped)
//   raddr_a/rdata_a         combinational read port A
//   raddr_b/rdata_b         combinational read port B
//   dbg_addr/dbg_data       combinational debug read port
// ---------------------------------------------------------------------------
module exec_regfile #(
    parameter  int DATA_W    = 32,
    parameter  int REG_COUNT = 32,
    localparam int AW        = $clog2(REG_COUNT)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr_a,
    output logic [DATA_W-1:0] rdata_a,
    input  logic [AW-1:0]     raddr_b,
    output logic [DATA_W-1:0] rdata_b,
    input  logic [AW-1:0]     dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    logic [DATA_W-1:0] regs [REG_COUNT];

    // NOTE: the array is reset because the architecture guarantees all
    // registers read 0 after reset; a plain RAM would normally not be reset.
    // NOTE: sequential state is always assigned with <= so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (waddr != '0)) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata_a  = (raddr_a  == '0) ? '0 : regs[raddr_a];
    assign rdata_b  = (raddr_b  == '0) ? '0 : regs[raddr_b];
    assign dbg_data = (dbg_addr == '0) ? '0 : regs[dbg_addr];

endmodule

// File: rtl/instruction_executor.sv
// ---------------------------------------------------------------------------
// instruction_executor
// Accepts one instruction per IDLE handshake and runs it through
// DECODE -> EXECUTE -> WRITEBACK (4 cycles per instruction).
// Ports:
//   clk, reset            clock, asynchronous active-low reset
//   instr, instr_valid    instruction input; instr_ready high only in IDLE
//   busy                  instruction in flight (state != IDLE)
//   wb_en/wb_addr/wb_data registered writeback event; addr/data hold between
//                         pulses
//   dbg_addr/dbg_data     combinational register read for debug
//   illegal               sticky illegal-opcode flag
// Optional build macro EXECUTOR_ILLEGAL_TRAP_EN: opcode 001 sets illegal and
// parks the FSM in HALT until reset. Without it, illegal is 0 and opcode 001
// behaves as a NOP.
// ---------------------------------------------------------------------------
module instruction_executor
    import exec_pkg::*;
#(
    parameter  int DATA_W    = 32,
    parameter  int REG_COUNT = 32,
    parameter  int IMM_W     = 16,
    localparam int AW        = $clog2(REG_COUNT)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [INSTR_W-1:0] instr,
    input  logic               instr_valid,
    output logic               instr_ready,
    output logic               busy,
    output logic               wb_en,
    output logic [AW-1:0]      wb_addr,
    output logic [DATA_W-1:0]  wb_data,
    input  logic [AW-1:0]      dbg_addr,
    output logic [DATA_W-1:0]  dbg_data,
    output logic               illegal
);

    state_t state, next_state;

    logic [INSTR_W-1:0] instr_q;
    logic [DATA_W-1:0]  opa_q, opb_q, result_q;
    logic [AW-1:0]      dest_q;
    logic               wr_q;

    logic [OP_W-1:0]    op;
    logic [AW-1:0]      rs_idx, rt_idx, rd_idx;
    logic [IMM_W-1:0]   imm;
    logic [DATA_W-1:0]  rs_val, rt_val, alu_out;
    logic [AW-1:0]      dec_dest;
    logic               rf_we;

    assign op     = instr_q[OP_LSB +: OP_W];
    assign rs_idx = instr_q[RS_LSB +: AW];
    assign rt_idx = instr_q[RT_LSB +: AW];
    assign rd_idx = instr_q[RD_LSB +: AW];
    assign imm    = instr_q[IMM_LSB +: IMM_W];

    assign dec_dest = op_is_itype(op) ? rt_idx : rd_idx;
    assign rf_we    = (state == WRITEBACK) && wr_q;

    exec_regfile #(
        .DATA_W    (DATA_W),
        .REG_COUNT (REG_COUNT)
    ) u_regfile (
        .clk      (clk),
        .reset    (reset),
        .we       (rf_we),
        .waddr    (dest_q),
        .wdata    (result_q),
        .raddr_a  (rs_idx),
        .rdata_a  (rs_val),
        .raddr_b  (rt_idx),
        .rdata_b  (rt_val),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    // ALU works on the operands captured in DECODE; instr_q still holds the
    // opcode because nothing new is accepted until IDLE.
    always_comb begin
        alu_out = '0;
        case (op)
            OP_ADD, OP_ADDI: alu_out = opa_q + opb_q;
            OP_SUB, OP_SUBI: alu_out = opa_q - opb_q;
            OP_SHIFTL:       alu_out = opa_q << opb_q[SHAMT_W-1:0];
            OP_SHIFTR:       alu_out = opa_q >> opb_q[SHAMT_W-1:0];
            default:         alu_out = '0;
        endcase
    end

    // NOTE: next_state gets its default before the case so that no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:      if (instr_valid) next_state = DECODE;
`ifdef EXECUTOR_ILLEGAL_TRAP_EN
            DECODE:    next_state = (op == OP_RSVD) ? HALT : EXECUTE;
`else
            DECODE:    next_state = EXECUTE;
`endif
            EXECUTE:   next_state = WRITEBACK;
            WRITEBACK: next_state = IDLE;
            HALT:      next_state = HALT;
            default:   next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instr_q  <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            dest_q   <= '0;
            wr_q     <= 1'b0;
            result_q <= '0;
        end else begin
            case (state)
                IDLE: if (instr_valid) instr_q <= instr;
                DECODE: begin
                    // Operands are read here, before this instruction's own
                    // write, so rs = rt = rd sees the old values.
                    opa_q  <= rs_val;
                    opb_q  <= op_is_itype(op)
                              ? {{(DATA_W-IMM_W){1'b0}}, imm} : rt_val;
                    dest_q <= dec_dest;
                    wr_q   <= op_writes_reg(op) && (dec_dest != '0);
                end
                EXECUTE: result_q <= alu_out;
                default: ;
            endcase
        end
    end

    // Writeback event is registered on the same edge as the register write,
    // so the pulse and the updated dbg_data appear in the same cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wb_en   <= 1'b0;
            wb_addr <= '0;
            wb_data <= '0;
        end else begin
            wb_en <= rf_we;
            if (rf_we) begin
                wb_addr <= dest_q;
                wb_data <= result_q;
            end
        end
    end

`ifdef EXECUTOR_ILLEGAL_TRAP_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            illegal <= 1'b0;
        end else if (state == DECODE && op == OP_RSVD) begin
            illegal <= 1'b1;
        end
    end
`else
    assign illegal = 1'b0;
`endif

    assign instr_ready = (state == IDLE);
    assign busy        = (state != IDLE);

endmodule

// File: tb/tb_instruction_executor.sv
// ---------------------------------------------------------------------------
// tb_instruction_executor
// Directed self-checking bench for instruction_executor. Inputs are driven
// and outputs sampled 1 time unit after the rising edge.
// ---------------------------------------------------------------------------
module tb_instruction_executor;
    import exec_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic        busy;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_data;
    logic        illegal;

    int vectors = 0;
    int errors  = 0;

    logic [4:0]  last_addr;
    logic [31:0] last_data;

    always #5 clk = ~clk;

    instruction_executor dut (
        .clk         (clk),
        .reset       (reset),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .busy        (busy),
        .wb_en       (wb_en),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data),
        .illegal     (illegal)
    );

    function automatic logic [31:0] rtype(input logic [2:0] op, input logic [4:0] rd,
                                          input logic [4:0] rs, input logic [4:0] rt);
        return {op, rs, rt, rd, 14'd0};
    endfunction

    function automatic logic [31:0] itype(input logic [2:0] op, input logic [4:0] rt,
                                          input logic [4:0] rs, input logic [15:0] imm);
        return {op, rs, rt, 3'd0, imm};
    endfunction

    task automatic dbg_expect(input string name, input logic [4:0] a, input logic [31:0] exp);
        dbg_addr = a;
        #1;
        vectors++;
        if (dbg_data !== exp) begin
            errors++;
            $display("FAIL %s dbg r%0d: got %h expected %h", name, a, dbg_data, exp);
        end
    endtask

    // Issue one instruction from IDLE and follow it for 4 cycles.
    task automatic exec_check(input string name, input logic [31:0] word, input logic exp_wb,
                              input logic [4:0] exp_addr, input logic [31:0] exp_data);
        instr       = word;
        instr_valid = 1'b1;
        vectors++;
        if (instr_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s ready before accept: got %b expected 1", name, instr_ready);
        end
        @(posedge clk); #1;
        instr_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (wb_en !== 1'b0 || busy !== 1'b1 || instr_ready !== 1'b0) begin
                errors++;
                $display("FAIL %s in-flight cycle %0d: wb_en/busy/ready got %b%b%b expected 010",
                         name, i + 1, wb_en, busy, instr_ready);
            end
            @(posedge clk); #1;
        end
        vectors++;
        if (wb_en !== exp_wb) begin
            errors++;
            $display("FAIL %s wb_en: got %b expected %b", name, wb_en, exp_wb);
        end
        if (exp_wb) begin
            last_addr = exp_addr;
            last_data = exp_data;
        end
        vectors++;
        if (wb_addr !== last_addr || wb_data !== last_data) begin
            errors++;
            $display("FAIL %s wb_addr/wb_data: got %0d/%h expected %0d/%h",
                     name, wb_addr, wb_data, last_addr, last_data);
        end
    endtask

    task automatic test_reset();
        reset       = 1'b0;
        instr       = '0;
        instr_valid = 1'b0;
        dbg_addr    = '0;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (busy !== 1'b0 || wb_en !== 1'b0 || wb_addr !== 5'd0 || wb_data !== 32'd0 ||
            illegal !== 1'b0) begin
            errors++;
            $display("FAIL reset outputs: busy=%b wb_en=%b wb_addr=%0d wb_data=%h illegal=%b expected all 0",
                     busy, wb_en, wb_addr, wb_data, illegal);
        end
        reset = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if (instr_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset ready: got %b expected 1", instr_ready);
        end
        last_addr = '0;
        last_data = '0;
        dbg_expect("reset", 5'd5, 32'd0);
    endtask

    task automatic test_stream();
        exec_check("addi r10", itype(OP_ADDI, 5'd10, 5'd0, 16'd10), 1'b1, 5'd10, 32'd10);
        exec_check("addi r15", itype(OP_ADDI, 5'd15, 5'd0, 16'd15), 1'b1, 5'd15, 32'd15);
        exec_check("add r25", rtype(OP_ADD, 5'd25, 5'd10, 5'd15), 1'b1, 5'd25, 32'd25);
        exec_check("subi r20", itype(OP_SUBI, 5'd20, 5'd25, 16'd5), 1'b1, 5'd20, 32'd20);
        exec_check("addi r5", itype(OP_ADDI, 5'd5, 5'd0, 16'd2), 1'b1, 5'd5, 32'd2);
        exec_check("shiftl r30", rtype(OP_SHIFTL, 5'd30, 5'd25, 5'd5), 1'b1, 5'd30, 32'd100);
        dbg_expect("stream", 5'd30, 32'd100);
    endtask

    // instr_valid held high: accepts at cycles 0, 4, 8; wb 3 edges after each.
    task automatic test_back_to_back();
        instr       = itype(OP_ADDI, 5'd6, 5'd0, 16'd6);
        instr_valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            vectors++;
            if (instr_ready !== (i % 4 == 0) || busy !== (i % 4 != 0)) begin
                errors++;
                $display("FAIL b2b ready/busy cycle %0d: got %b%b expected %b%b",
                         i, instr_ready, busy, (i % 4 == 0), (i % 4 != 0));
            end
            @(posedge clk); #1;
            vectors++;
            if (wb_en !== (i % 4 == 3)) begin
                errors++;
                $display("FAIL b2b wb_en cycle %0d: got %b expected %b", i, wb_en, (i % 4 == 3));
            end
        end
        instr_valid = 1'b0;
        last_addr   = 5'd6;
        last_data   = 32'd6;
        vectors++;
        if (wb_addr !== last_addr || wb_data !== last_data) begin
            errors++;
            $display("FAIL b2b wb value: got %0d/%h expected 6/00000006", wb_addr, wb_data);
        end
    endtask

    task automatic test_wrap_shift();
        exec_check("subi wrap", itype(OP_SUBI, 5'd1, 5'd0, 16'd1), 1'b1, 5'd1, 32'hFFFF_FFFF);
        exec_check("addi r31", itype(OP_ADDI, 5'd31, 5'd0, 16'd36), 1'b1, 5'd31, 32'd36);
        exec_check("shiftr", rtype(OP_SHIFTR, 5'd2, 5'd1, 5'd31), 1'b1, 5'd2, 32'h0FFF_FFFF);
        exec_check("add same reg", rtype(OP_ADD, 5'd1, 5'd1, 5'd1), 1'b1, 5'd1, 32'hFFFF_FFFE);
        dbg_expect("same reg", 5'd1, 32'hFFFF_FFFE);
    endtask

    task automatic test_r0_nop();
        exec_check("addi r0", itype(OP_ADDI, 5'd0, 5'd0, 16'd7), 1'b0, 5'd0, 32'd0);
        exec_check("nop", rtype(OP_NOP, 5'd9, 5'd1, 5'd2), 1'b0, 5'd0, 32'd0);
        dbg_expect("r0", 5'd0, 32'd0);
        dbg_expect("nop dest", 5'd9, 32'd0);
    endtask

    task automatic test_reset_mid();
        instr       = rtype(OP_ADD, 5'd3, 5'd1, 5'd2);
        instr_valid = 1'b1;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        @(posedge clk); #1;        // now in EXECUTE
        reset = 1'b0;
        #1;
        vectors++;
        if (busy !== 1'b0 || wb_en !== 1'b0 || wb_data !== 32'd0) begin
            errors++;
            $display("FAIL midreset outputs: busy=%b wb_en=%b wb_data=%h expected 0/0/0",
                     busy, wb_en, wb_data);
        end
        dbg_expect("midreset", 5'd1, 32'd0);
        dbg_expect("midreset", 5'd2, 32'd0);
        @(posedge clk); #1;
        reset     = 1'b1;
        last_addr = '0;
        last_data = '0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            vectors++;
            if (wb_en !== 1'b0 || instr_ready !== 1'b1) begin
                errors++;
                $display("FAIL midreset after release cycle %0d: wb_en/ready got %b%b expected 01",
                         i, wb_en, instr_ready);
            end
        end
        dbg_expect("midreset", 5'd3, 32'd0);
    endtask

    task automatic test_illegal();
`ifdef EXECUTOR_ILLEGAL_TRAP_EN
        instr       = itype(OP_RSVD, 5'd7, 5'd0, 16'd7);
        instr_valid = 1'b1;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        @(posedge clk); #1;        // DECODE done -> HALT
        vectors++;
        if (illegal !== 1'b1 || busy !== 1'b1 || instr_ready !== 1'b0) begin
            errors++;
            $display("FAIL trap entry: illegal/busy/ready got %b%b%b expected 110",
                     illegal, busy, instr_ready);
        end
        instr       = itype(OP_ADDI, 5'd8, 5'd0, 16'd8);
        instr_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            vectors++;
            if (wb_en !== 1'b0 || instr_ready !== 1'b0 || illegal !== 1'b1) begin
                errors++;
                $display("FAIL trap hold cycle %0d: wb_en/ready/illegal got %b%b%b expected 001",
                         i, wb_en, instr_ready, illegal);
            end
        end
        instr_valid = 1'b0;
        dbg_expect("trap", 5'd8, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if (illegal !== 1'b0 || instr_ready !== 1'b1) begin
            errors++;
            $display("FAIL trap reset: illegal/ready got %b%b expected 01", illegal, instr_ready);
        end
        last_addr = '0;
        last_data = '0;
        exec_check("after trap", itype(OP_ADDI, 5'd8, 5'd0, 16'd8), 1'b1, 5'd8, 32'd8);
`else
        exec_check("reserved", itype(OP_RSVD, 5'd7, 5'd0, 16'd7), 1'b0, 5'd0, 32'd0);
        vectors++;
        if (illegal !== 1'b0) begin
            errors++;
            $display("FAIL reserved illegal: got %b expected 0", illegal);
        end
        dbg_expect("reserved", 5'd7, 32'd0);
        exec_check("after reserved", itype(OP_ADDI, 5'd8, 5'd0, 16'd8), 1'b1, 5'd8, 32'd8);
`endif
    endtask

    initial begin
        test_reset();
        test_stream();
        test_back_to_back();
        test_wrap_shift();
        test_r0_nop();
        test_reset_mid();
        test_illegal();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within 200000 time units");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/instruction_executor.md
Name: instruction_executor

Overview:
- Consumer end of the instruction stream produced by the fetch block: accepts one 32-bit instruction per handshake, decodes it, executes it on an internal 32x32 register file and writes the result back.
- Multi-cycle FSM. Sits between instruction fetch and the debug/observation logic.
- Exposes a writeback event bus and a combinational debug read port.

Parameters:
- DATA_W, 32, register and ALU width.
- REG_COUNT, 32, number of registers; register index width = log2(REG_COUNT) = 5.
- IMM_W, 16, immediate width, zero-extended to DATA_W.

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- instr  input  32  instruction word.
- instr_valid  input  1  instr is valid this cycle.
- instr_ready  output  1  executor can accept an instruction.
- busy  output  1  an instruction is in flight (state != IDLE).
- wb_en  output  1  one-cycle pulse: a register was written.
- wb_addr  output  5  destination register of the write.
- wb_data  output  DATA_W  value written.
- dbg_addr  input  5  debug register select.
- dbg_data  output  DATA_W  combinational read of register dbg_addr.
- illegal  output  1  sticky illegal-opcode flag (only with the optional feature).

Behaviour:
- Instruction format:
  - op = [31:29], rs = [28:24], rt = [23:19].
  - R-type: rd = [18:14]; bits [13:0] ignored.
  - I-type: destination = rt; imm = [15:0]; bits [18:16] ignored.
- Opcodes:
  - 000 NOP.
  - 001 reserved.
  - 010 ADD rd = rs + rt.
  - 011 SUB rd = rs - rt.
  - 100 SHIFTL rd = rs << rt[4:0].
  - 101 SHIFTR (logical) rd = rs >> rt[4:0].
  - 110 ADDI rt = rs + zext(imm).
  - 111 SUBI rt = rs - zext(imm).
- Arithmetic is modulo 2^DATA_W; no overflow flag.
- FSM states:
  - IDLE: instr_ready = 1. Accept when instr_valid & instr_ready; latch instr and go to DECODE.
  - DECODE: read rs/rt operands, select destination and immediate. Go to EXECUTE.
  - EXECUTE: register the ALU result. Go to WRITEBACK.
  - WRITEBACK: write the register file, pulse wb_en for exactly this cycle. Go to IDLE.
- Latency: an instruction accepted on edge N produces its wb_en pulse in the cycle after edge N+3. The next accept happens no earlier than edge N+4, so throughput is 1 instruction per 4 cycles.
- instr_ready = 0 in every state except IDLE. instr_valid asserted outside IDLE is ignored; it is not queued and the source holds it.
- NOP and reserved opcodes: pass through all states; wb_en stays 0.
- Destination r0: never written, reads as 0, wb_en suppressed.
- rs = rt = rd in one instruction: operands are read in DECODE, before the write, so old values are used.
- wb_addr/wb_data hold their last values between pulses.
- dbg_data reflects a register write on the cycle after the WRITEBACK edge.
- Reset (reset = 0), including mid-instruction:
  - state = IDLE, discarding any in-flight instruction.
  - All registers = 0.
  - wb_en = 0, wb_addr = 0, wb_data = 0, busy = 0, illegal = 0.
  - instr_ready = 1 once reset is released.

Optional Feature:
- Macro: EXECUTOR_ILLEGAL_TRAP_EN.
- With the macro defined:
  - Opcode 001 sets illegal = 1 in DECODE and enters a HALT state.
  - In HALT: instr_ready = 0, busy = 1, no writeback; only reset leaves HALT.
- Without the macro: the illegal port is tied to 0 and opcode 001 executes as a NOP.

Decomposition:
- Shared package exec_pkg holds:
  - opcode localparams (OP_NOP … OP_SUBI);
  - field bit positions / widths;
  - state enum (IDLE, DECODE, EXECUTE, WRITEBACK, HALT).
- Sub-module exec_regfile:
  - REG_COUNT x DATA_W;
  - two combinational read ports plus a debug read port;
  - one synchronous write port;
  - r0 hardwired to 0;
  - same clk and active-low asynchronous reset.

Test Plan:
- Reset, then stream ADDI r10,r0,10; ADDI r15,r0,15; ADD r25,r10,r15; SUBI r20,r25,5; ADDI r5,r0,2; SHIFTL r30,r25,r5 -> wb pulses (10,10) (15,15) (25,25) (20,20) (5,2) (30,100); dbg r30 = 100.
- Hold instr_valid high continuously -> instr_ready high only in IDLE; accepts spaced exactly 4 cycles; wb_en exactly 3 cycles after each accept.
- SUBI r1,r0,1 -> r1 = 0xFFFFFFFF (wrap). SHIFTR r2,r1,r(31) with r31 = 36 -> shift by 4 -> 0x0FFFFFFF.
- ADDI r0,r0,7, then NOP -> no wb_en pulse; dbg r0 = 0.
- Drive reset low during EXECUTE of ADD r3,r1,r2 -> no wb_en; all registers 0; instr_ready = 1 after release.
- Opcode 001 -> with EXECUTOR_ILLEGAL_TRAP_EN: illegal = 1 and further instructions are refused until reset. Without it: behaves as NOP.
